// File: rtl/mod_calc_pkg.sv
// Shared types and elaboration-time arithmetic helpers for the serial modular reducer.
// The helpers are evaluated as constant functions when the residue tables are built.
package mod_calc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Inputs must already be below m, so one conditional subtract is enough.
    function automatic int unsigned mod_add(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned m);
        longint unsigned s;
        s = 64'(a) + 64'(b);
        if (s >= 64'(m)) begin
            s = s - 64'(m);
        end
        return 32'(s);
    endfunction

    function automatic int unsigned mod_pow2(input int unsigned e,
                                             input int unsigned m);
        int unsigned r;
        r = 1 % m;
        for (int unsigned i = 0; i < e; i++) begin
            r = mod_add(r, r, m);
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_chunk_lut.sv
// Combinational per-position residue table: (idx, chunk) -> chunk*2^(BASE_SHIFT+CHUNK_W*idx) mod MODULUS.
// Every entry is a constant fixed at elaboration; no multiplier is built.
module mod_chunk_lut
    import mod_calc_pkg::*;
#(
    parameter int MODULUS    = 503,
    parameter int CHUNK_W    = 6,
    parameter int N_CHUNKS   = 8,
    parameter int BASE_SHIFT = 0,
    localparam int RES_W     = $clog2(MODULUS),
    localparam int IDX_W     = $clog2(N_CHUNKS + 1)
) (
    input  logic [IDX_W-1:0]   idx,
    input  logic [CHUNK_W-1:0] chunk,
    output logic [RES_W-1:0]   residue
);

    logic [RES_W-1:0] tbl    [N_CHUNKS][2**CHUNK_W];
    logic [RES_W-1:0] or_acc [N_CHUNKS+1];

    assign or_acc[0] = '0;

    for (genvar gi = 0; gi < N_CHUNKS; gi++) begin : g_pos
        localparam int unsigned WEIGHT = mod_pow2(BASE_SHIFT + CHUNK_W * gi, MODULUS);

        for (genvar gj = 0; gj < 2**CHUNK_W; gj++) begin : g_val
            localparam longint unsigned ENTRY = (64'(gj) * 64'(WEIGHT)) % 64'(MODULUS);
            assign tbl[gi][gj] = RES_W'(ENTRY);
        end

        // One-hot select on idx folded into an OR chain; out-of-range idx yields 0.
        assign or_acc[gi+1] = or_acc[gi] |
                              ((idx == IDX_W'(gi)) ? tbl[gi][chunk] : '0);
    end

    assign residue = or_acc[N_CHUNKS];

endmodule

// File: rtl/mod_reduce_serial.sv
// Time-multiplexed modular reducer: one CHUNK_W slice per cycle through a residue table,
// folded into a modular accumulator, with valid/ready handshakes on both sides.
module mod_reduce_serial
    import mod_calc_pkg::*;
#(
    parameter int MODULUS    = 503,
    parameter int IN_W       = 48,
    parameter int CHUNK_W    = 6,
    parameter int BASE_SHIFT = 0,
    parameter int SKIP_ZERO  = 0,
    localparam int N_CHUNKS  = (IN_W + CHUNK_W - 1) / CHUNK_W,
    localparam int RES_W     = $clog2(MODULUS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_residue,
    output logic             busy
);

    localparam int OP_W  = N_CHUNKS * CHUNK_W;
    localparam int IDX_W = $clog2(N_CHUNKS + 1);
    localparam logic [RES_W:0] MOD_X = (RES_W+1)'(MODULUS);

    if (MODULUS < 2 || MODULUS >= 2**RES_W) begin : g_bad_modulus
        $error("mod_reduce_serial: MODULUS must satisfy 2 <= MODULUS < 2**RES_W");
    end
    if (CHUNK_W < 1) begin : g_bad_chunk
        $error("mod_reduce_serial: CHUNK_W must be at least 1");
    end
    if (IN_W < CHUNK_W) begin : g_bad_width
        $error("mod_reduce_serial: IN_W must be at least CHUNK_W");
    end

    state_e           state_q, state_d;
    logic [OP_W-1:0]  opnd_q, opnd_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [RES_W-1:0] acc_q, acc_d;
    logic             rdy_q, rdy_d;

    logic [RES_W-1:0] lut_res;
    logic [RES_W:0]   sum_raw;
    logic [RES_W-1:0] acc_add;
    logic             last_slice;

    // The operand register shifts right each RUN cycle, so the active slice is always the LSBs.
    mod_chunk_lut #(
        .MODULUS    (MODULUS),
        .CHUNK_W    (CHUNK_W),
        .N_CHUNKS   (N_CHUNKS),
        .BASE_SHIFT (BASE_SHIFT)
    ) u_lut (
        .idx     (idx_q),
        .chunk   (opnd_q[CHUNK_W-1:0]),
        .residue (lut_res)
    );

    always_comb begin
        sum_raw = {1'b0, acc_q} + {1'b0, lut_res};
        acc_add = (sum_raw >= MOD_X) ? RES_W'(sum_raw - MOD_X) : sum_raw[RES_W-1:0];
    end

    assign last_slice = (idx_q == IDX_W'(N_CHUNKS - 1)) ||
                        ((SKIP_ZERO != 0) && ((opnd_q >> CHUNK_W) == '0));

    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && rdy_q) begin
                    opnd_d  = OP_W'(in_data);
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d  = acc_add;
                idx_d  = idx_q + IDX_W'(1);
                opnd_d = opnd_q >> CHUNK_W;
                if (last_slice) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered ready keeps in_ready low while reset is held and for no longer.
        rdy_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            opnd_q  <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            rdy_q   <= rdy_d;
        end
    end

    assign in_ready    = rdy_q;
    assign out_valid   = (state_q == ST_DONE);
    assign out_residue = acc_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mod_reduce_serial.sv
// Scoreboard bench for mod_reduce_serial: four instances (default, BASE_SHIFT=9, BASE_SHIFT=12,
// SKIP_ZERO=1); a driver queues expected residue/latency, a monitor pops and checks on out_valid.
module tb_mod_reduce_serial;

    localparam int ND = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid    [ND];
    logic [47:0] in_data     [ND];
    logic        in_ready    [ND];
    logic        out_valid   [ND];
    logic        out_ready   [ND];
    logic [8:0]  out_residue [ND];
    logic        busy        [ND];

    typedef struct {
        int              dut;
        longint unsigned data;
        int              res;
        int              lat;
        longint          acc_cyc;
    } exp_t;

    exp_t   sb_q[$];
    longint cyc = 0;
    int     n_cmp = 0;
    int     n_bad = 0;
    bit     bp_en = 1'b0;
    bit     seen  [ND];
    int     hold  [ND];
    int     held_res [ND];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < ND; gi++) begin : g_dut
        mod_reduce_serial #(
            .MODULUS    (503),
            .IN_W       (48),
            .CHUNK_W    (6),
            .BASE_SHIFT ((gi == 1) ? 9 : ((gi == 2) ? 12 : 0)),
            .SKIP_ZERO  ((gi == 3) ? 1 : 0)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_valid    (in_valid[gi]),
            .in_ready    (in_ready[gi]),
            .in_data     (in_data[gi]),
            .out_valid   (out_valid[gi]),
            .out_ready   (out_ready[gi]),
            .out_residue (out_residue[gi]),
            .busy        (busy[gi])
        );
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Offer one operand to instance k and queue what must come back.
    task automatic issue(input int k, input longint unsigned d, input int exp_res, input int exp_lat);
        exp_t e;
        int   t;
        @(negedge clk);
        in_valid[k] = 1'b1;
        in_data[k]  = d[47:0];
        t = 0;
        while (!in_ready[k] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready[k]) begin
            chk("accept_timeout", 0, 1);
            in_valid[k] = 1'b0;
        end else begin
            e.dut = k; e.data = d; e.res = exp_res; e.lat = exp_lat; e.acc_cyc = cyc;
            sb_q.push_back(e);
            @(negedge clk);
            in_valid[k] = 1'b0;
            in_data[k]  = 48'($urandom) ^ 48'hA5A5_5A5A_F0F0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb_q.size() != 0 || busy[0] || busy[1] || busy[2] || busy[3]) && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) chk("drain_timeout", 0, 1);
    endtask

    // Monitor: pops on the first cycle of each result, then applies random backpressure.
    initial begin
        exp_t e;
        for (int k = 0; k < ND; k++) begin
            out_ready[k] = 1'b1; seen[k] = 1'b0; hold[k] = 0; held_res[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < ND; k++) begin
                if (!rst_n) begin
                    seen[k] = 1'b0;
                end else if (out_valid[k]) begin
                    if (!seen[k]) begin
                        seen[k] = 1'b1;
                        if (sb_q.size() == 0) begin
                            chk("unexpected_result", 1, 0);
                            held_res[k] = int'(out_residue[k]);
                        end else begin
                            e = sb_q.pop_front();
                            chk("result_dut", k, e.dut);
                            chk("residue", longint'(out_residue[k]), e.res);
                            chk("latency", cyc - e.acc_cyc, e.lat);
                            held_res[k] = e.res;
                            $display("dut%0d data=0x%012h residue=%0d expected=%0d latency=%0d",
                                     k, e.data, out_residue[k], e.res, cyc - e.acc_cyc);
                        end
                        hold[k] = bp_en ? int'($urandom_range(0, 5)) : 0;
                    end else if (hold[k] > 0) begin
                        hold[k]--;
                    end
                    out_ready[k] = (hold[k] == 0);
                    if (out_ready[k]) begin
                        chk("held_residue", longint'(out_residue[k]), held_res[k]);
                        seen[k] = 1'b0;
                    end
                end else begin
                    out_ready[k] = 1'b1;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint unsigned x;
        int t;
        for (int k = 0; k < ND; k++) begin
            in_valid[k] = 1'b0;
            in_data[k]  = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("in_ready_in_reset", in_ready[0], 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready[0], 1);
        chk("rst_out_valid", out_valid[0], 0);
        chk("rst_out_residue", out_residue[0], 0);
        chk("rst_busy", busy[0], 0);

        issue(0, 64'd1000, 497, 9);            drain();
        issue(0, 64'd503, 0, 9);               drain();
        issue(0, 64'd0, 0, 9);                 drain();
        issue(0, 64'hFFFF_FFFF_FFFF, 74, 9);   drain();
        issue(1, 64'd1, 9, 9);                 drain();
        issue(2, 64'd1, 72, 9);                drain();
        issue(3, 64'd5, 5, 2);                 drain();
        issue(3, 64'd0, 0, 2);                 drain();
        issue(3, 64'd1000, 497, 3);            drain();
        issue(3, 64'h8000_0000_0000, 289, 9);  drain();

        // Abort an operation in its fourth RUN cycle.
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0]  = 48'd1000;
        t = 0;
        while (!in_ready[0] && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("abort_accept", in_ready[0], 1);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_before", busy[0], 1);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", in_ready[0], 0);
        chk("abort_out_valid", out_valid[0], 0);
        chk("abort_out_residue", out_residue[0], 0);
        chk("abort_busy", busy[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(0, 64'd1000, 497, 9);            drain();

        bp_en = 1'b1;
        for (int n = 0; n < 500; n++) begin
            x = {$urandom, $urandom} & 64'h0000_FFFF_FFFF_FFFF;
            if (n % 7 == 0) x = x >> $urandom_range(0, 47);
            issue(0, x, int'(x % 64'd503), 9);
        end
        drain();
        bp_en = 1'b0;

        repeat (5) @(negedge clk);
        chk("leftover_expected", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
